// File: rtl/usb_packet_sequencer.sv
// usb_packet_sequencer: FIFO read-side sequencer for the sampler datapath.
// Waits for one full packet in the FIFO plus FX3 buffer space, then issues
// exactly PACKET_WORDS back-to-back reads and a write strobe that follows the
// read requests by RD_LATENCY cycles.
// Optional: define USB_SEQ_PKTCOUNT_EN to build the packetCount register;
// otherwise packetCount is tied to 0.
module usb_packet_sequencer #(
  parameter int PACKET_WORDS = 8192,
  parameter int RD_LATENCY   = 2,
  parameter int PKTCNT_WIDTH = 16
) (
  input  logic                    fx3Clk,
  input  logic                    nReset,
  input  logic                    collectData,
  input  logic                    dataAvailable,
  input  logic                    bufferError,
  input  logic                    fx3Ready,
  output logic                    readData,
  output logic                    fx3Write,
  output logic                    packetDone,
  output logic                    errorLatched,
  output logic                    busy,
  output logic [PKTCNT_WIDTH-1:0] packetCount
);

  localparam int CNT_W = $clog2(PACKET_WORDS);

  typedef enum logic [2:0] {IDLE, WAIT_DATA, BURST, DRAIN, ERROR} state_t;

  state_t            state, nextState;
  logic [CNT_W-1:0]  wordCnt;
  logic              pendErr;
  logic              lastRead;
  logic              startCollect;
  // Bit i holds the read strobe (or last-read marker) delayed by i cycles.
  logic [RD_LATENCY:1] wrPipe, lastPipe;

  // readData is registered as (state == BURST), so the final read is the
  // BURST cycle with the counter at its top value.
  assign lastRead     = (state == BURST) && (wordCnt == CNT_W'(PACKET_WORDS - 1));
  assign startCollect = (state == IDLE) && collectData;
  assign fx3Write     = wrPipe[RD_LATENCY];
  assign packetDone   = lastPipe[RD_LATENCY];

  // Next-state logic; DRAIN ends on the cycle the last write leaves the pipe.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (collectData) nextState = WAIT_DATA;
      WAIT_DATA: begin
        if (!collectData)                nextState = IDLE;
        else if (bufferError)            nextState = ERROR;
        else if (dataAvailable && fx3Ready) nextState = BURST;
      end
      BURST:     if (lastRead) nextState = DRAIN;
      DRAIN: begin
        if (packetDone) begin
          if (pendErr || bufferError) nextState = ERROR;
          else if (!collectData)      nextState = IDLE;
          else                        nextState = WAIT_DATA;
        end
      end
      ERROR:     if (!collectData) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  // State register plus registered control outputs and burst bookkeeping.
  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      state        <= IDLE;
      readData     <= 1'b0;
      busy         <= 1'b0;
      errorLatched <= 1'b0;
      wordCnt      <= '0;
      pendErr      <= 1'b0;
    end else begin
      state    <= nextState;
      readData <= (nextState == BURST);
      busy     <= (nextState != IDLE);
      // Counter wraps to 0 after the last read since PACKET_WORDS is 2^n.
      wordCnt  <= (state == BURST) ? wordCnt + 1'b1 : '0;
      // An error seen while a packet is in flight is deferred to packet end.
      if ((state == BURST || state == DRAIN) && bufferError)
        pendErr <= 1'b1;
      else if (state == IDLE || state == WAIT_DATA)
        pendErr <= 1'b0;
      if (startCollect)
        errorLatched <= 1'b0;
      else if (nextState == ERROR)
        errorLatched <= 1'b1;
    end
  end

  // Delay the read strobe and last-read marker to line up with dataOut.
  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset) begin
      wrPipe   <= '0;
      lastPipe <= '0;
    end else begin
      wrPipe[1]   <= readData;
      lastPipe[1] <= lastRead;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        wrPipe[i]   <= wrPipe[i-1];
        lastPipe[i] <= lastPipe[i-1];
      end
    end
  end

`ifdef USB_SEQ_PKTCOUNT_EN
  // doneNext is high the cycle before packetDone, so the count updates
  // on the same edge that raises packetDone.
  logic doneNext;
  if (RD_LATENCY == 1) begin : g_doneLat1
    assign doneNext = lastRead;
  end else begin : g_doneLatN
    assign doneNext = lastPipe[RD_LATENCY-1];
  end

  // Completed-packet counter, cleared when a new collection starts.
  always_ff @(posedge fx3Clk or negedge nReset) begin
    if (!nReset)           packetCount <= '0;
    else if (startCollect) packetCount <= '0;
    else if (doneNext)     packetCount <= packetCount + 1'b1;
  end
`else
  assign packetCount = '0;
`endif

endmodule

// File: doc/usb_packet_sequencer.md
Name: usb_packet_sequencer

Overview:
- Controls the FIFO read side of the sampler datapath in the fx3Clk domain.
- Waits until the dual-clock FIFO holds one full packet and the FX3 GPIF has buffer space. Then issues exactly PACKET_WORDS consecutive FIFO read requests.
- Generates a write strobe aligned to the delayed 16-bit output data.
- Tracks packet boundaries, latches buffer errors, and stops transfers cleanly when collection ends.

Parameters:
- PACKET_WORDS, 8192: FIFO words per USB packet (power of two, ≥4).
- RD_LATENCY, 2: fx3Clk cycles from readData high to the word being valid on dataOut (FIFO q plus conversion register). Legal range 1–7.
- PKTCNT_WIDTH, 16: width of packetCount.

Ports:
- fx3Clk  in  1  sole clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- collectData  in  1  capture enable, synchronous to fx3Clk.
- dataAvailable  in  1  FIFO holds ≥ PACKET_WORDS words.
- bufferError  in  1  FIFO near-full/overflow flag.
- fx3Ready  in  1  FX3 DMA buffer can accept a full packet (GPIF watermark flag).
- readData  out  1  FIFO read request.
- fx3Write  out  1  dataOut word valid; write strobe to FX3.
- packetDone  out  1  one-cycle pulse coincident with the last fx3Write of a packet.
- errorLatched  out  1  sticky buffer error indication.
- busy  out  1  high in any state except IDLE.
- packetCount  out  PKTCNT_WIDTH  completed packets since collection started.

Behaviour:
- **Reset (asynchronous):** state=IDLE. All outputs 0. Word counter and write-delay pipeline cleared. Reset during a burst aborts it immediately; there is no drain.
- **States:** IDLE, WAIT_DATA, BURST, DRAIN, ERROR. The state register and outputs are registered.
- **IDLE:**
  - collectData=1 → WAIT_DATA next cycle.
  - On that transition, packetCount is cleared and errorLatched is cleared.
- **WAIT_DATA:**
  - collectData=0 → IDLE.
  - Else bufferError=1 → ERROR.
  - Else dataAvailable=1 and fx3Ready=1 in the same cycle → BURST.
  - readData=0 throughout.
- **BURST:**
  - readData=1 for exactly PACKET_WORDS consecutive cycles; the word counter runs 0..PACKET_WORDS-1.
  - fx3Ready, dataAvailable and collectData are ignored mid-burst so packets are never truncated.
  - bufferError=1 sets a pending-error bit; the burst still completes.
  - Counter at PACKET_WORDS-1 → DRAIN.
- **fx3Write:**
  - Equals readData delayed by RD_LATENCY cycles through a shift register, in every state.
  - Therefore exactly PACKET_WORDS fx3Write cycles per burst.
- **DRAIN:**
  - Held for RD_LATENCY cycles until the last fx3Write.
  - packetDone pulses on the cycle of the last fx3Write.
  - packetCount increments on that cycle, wrapping modulo 2^PKTCNT_WIDTH.
  - Exit: pending-error bit or bufferError → ERROR; else collectData=0 → IDLE; else → WAIT_DATA.
  - Back-to-back bursts are permitted, with a minimum gap of RD_LATENCY+1 idle readData cycles.
- **ERROR:**
  - errorLatched=1 and readData=0.
  - Stays in ERROR until collectData=0, then → IDLE. errorLatched stays 1 until the next IDLE→WAIT_DATA transition.
- **busy:** 1 in WAIT_DATA, BURST, DRAIN and ERROR.
- **Simultaneous events:** bufferError takes priority over starting a burst in WAIT_DATA. In DRAIN, collectData=0 together with an error → ERROR, and then IDLE on the following cycle.

Optional Feature:
- Macro: USB_SEQ_PKTCOUNT_EN.
- **Defined:** packetCount operates as described above.
- **Undefined:** packetCount is tied to 0 and no counter register is synthesised. All other behaviour is identical.

Test Plan:
- **Basic packet:** PACKET_WORDS=16, RD_LATENCY=2, collectData=1, dataAvailable=1, fx3Ready=1 → readData high for 16 cycles starting 1 cycle after entering WAIT_DATA. fx3Write high for 16 cycles, 2 cycles later. packetDone pulses with write #16. packetCount=1.
- **FX3 backpressure:** dataAvailable=1, fx3Ready=0 for 50 cycles, then 1 → no readData for 50 cycles. The burst then starts and 16 reads are issued. fx3Ready dropped at read #5 → all 16 reads still issued.
- **Collection stop mid-burst:** collectData falls at read #8 → the remaining 8 reads complete, DRAIN runs, packetDone pulses, state=IDLE, busy=0 after the last fx3Write.
- **Error mid-burst:** bufferError pulses at read #3 → 16 reads complete, then ERROR, errorLatched=1 and readData stays 0. Then collectData=0 → IDLE with errorLatched still 1. collectData=1 again → errorLatched=0 and packetCount=0.
- **Async reset mid-burst:** nReset low at read #10 → readData, fx3Write, busy and packetDone all go to 0 immediately. After release the block is in IDLE with no stray fx3Write.
- **Counter wrap:** PKTCNT_WIDTH=2, run 5 packets → packetCount sequence 1,2,3,0,1. With USB_SEQ_PKTCOUNT_EN undefined, packetCount=0 throughout.
